// File: rtl/axi_ram_arbiter_if.sv
// rtl/axi_ram_arbiter_if.sv - AXI channel bundle between requesters, arbiter and RAM
//
// Purpose: one AXI-style channel set (AW, AR, W, R, B) used for each requester
//          link and for the shared RAM link.
// Modports:
//   master - issues requests: aw*/ar* address+valid, wdata/wvalid, rready, bready
//   slave  - answers requests: awready, arready, wready, rdata/rvalid, bvalid

interface axi_interface;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awlen, awvalid, araddr, arlen, arvalid,
    output wdata, wvalid, rready, bready,
    input  awready, arready, wready, rdata, rvalid, bvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid, araddr, arlen, arvalid,
    input  wdata, wvalid, rready, bready,
    output awready, arready, wready, rdata, rvalid, bvalid
  );
endinterface

// File: rtl/axi_ram_arbiter.sv
// rtl/axi_ram_arbiter.sv - two-requester AXI arbiter onto a single internal RAM port
//
// Purpose: grants one of two requesters (port 0 = L2 cache, high priority;
//          port 1 = loader/DMA, low priority) exclusive use of the RAM link for
//          one whole burst. Port 1 is forced through after STARVE_LIMIT
//          back-to-back port-0 grants made while it waited.
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset_n  - synchronous active-low reset
//   axi_m0   - requester 0 link (arbiter acts as slave)
//   axi_m1   - requester 1 link (arbiter acts as slave)
//   axi_ram  - shared RAM link (arbiter acts as master)

module axi_ram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  axi_interface.slave  axi_m0,
  axi_interface.slave  axi_m1,
  axi_interface.master axi_ram
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] READ_ADDR  = 3'd1;
  localparam logic [2:0] READ_DATA  = 3'd2;
  localparam logic [2:0] WRITE_ADDR = 3'd3;
  localparam logic [2:0] WRITE_DATA = 3'd4;
  localparam logic [2:0] WRITE_RESP = 3'd5;

  logic [2:0]    state;
  logic          grant;
  logic [7:0]    beat_cnt;
  logic [SW-1:0] starve_cnt;

  // Request fields of whichever port currently owns the RAM link
  logic [31:0] sel_awaddr, sel_araddr, sel_wdata;
  logic [7:0]  sel_awlen, sel_arlen;
  logic        sel_awvalid, sel_arvalid, sel_wvalid, sel_rready, sel_bready;

  always_comb begin
    sel_awaddr  = axi_m0.awaddr;
    sel_awlen   = axi_m0.awlen;
    sel_awvalid = axi_m0.awvalid;
    sel_araddr  = axi_m0.araddr;
    sel_arlen   = axi_m0.arlen;
    sel_arvalid = axi_m0.arvalid;
    sel_wdata   = axi_m0.wdata;
    sel_wvalid  = axi_m0.wvalid;
    sel_rready  = axi_m0.rready;
    sel_bready  = axi_m0.bready;
    if (grant) begin
      sel_awaddr  = axi_m1.awaddr;
      sel_awlen   = axi_m1.awlen;
      sel_awvalid = axi_m1.awvalid;
      sel_araddr  = axi_m1.araddr;
      sel_arlen   = axi_m1.arlen;
      sel_arvalid = axi_m1.arvalid;
      sel_wdata   = axi_m1.wdata;
      sel_wvalid  = axi_m1.wvalid;
      sel_rready  = axi_m1.rready;
      sel_bready  = axi_m1.bready;
    end
  end

  // Arbitration decision, only acted upon in IDLE
  logic pend0, pend1, arb_pick, pick_awvalid;
  assign pend0        = axi_m0.awvalid | axi_m0.arvalid;
  assign pend1        = axi_m1.awvalid | axi_m1.arvalid;
  assign arb_pick     = !pend0 || (pend1 && (starve_cnt == STARVE_MAX));
  assign pick_awvalid = arb_pick ? axi_m1.awvalid : axi_m0.awvalid;

  // Phase qualifiers; reset_n gates them so nothing leaks out while in reset
  logic in_ar, in_r, in_aw, in_w, in_b;
  assign in_ar = reset_n && (state == READ_ADDR);
  assign in_r  = reset_n && (state == READ_DATA);
  assign in_aw = reset_n && (state == WRITE_ADDR);
  assign in_w  = reset_n && (state == WRITE_DATA);
  assign in_b  = reset_n && (state == WRITE_RESP);

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  assign ar_hs = in_ar && sel_arvalid && axi_ram.arready;
  assign r_hs  = in_r  && axi_ram.rvalid && sel_rready;
  assign aw_hs = in_aw && sel_awvalid && axi_ram.awready;
  assign w_hs  = in_w  && sel_wvalid && axi_ram.wready;
  assign b_hs  = in_b  && axi_ram.bvalid && sel_bready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      beat_cnt   <= 8'd0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend0 || pend1) begin
            grant <= arb_pick;
            state <= pick_awvalid ? WRITE_ADDR : READ_ADDR;
          end
        end
        READ_ADDR: begin
          if (ar_hs) begin
            beat_cnt <= sel_arlen;
            state    <= READ_DATA;
          end
        end
        READ_DATA: begin
          // beat_cnt holds beats remaining after the current one
          if (r_hs) begin
            if (beat_cnt == 8'd0) state <= IDLE;
            else                  beat_cnt <= beat_cnt - 8'd1;
          end
        end
        WRITE_ADDR: begin
          if (aw_hs) begin
            beat_cnt <= sel_awlen;
            state    <= WRITE_DATA;
          end
        end
        WRITE_DATA: begin
          if (w_hs) begin
            if (beat_cnt == 8'd0) state <= WRITE_RESP;
            else                  beat_cnt <= beat_cnt - 8'd1;
          end
        end
        WRITE_RESP: begin
          if (b_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Starvation count: only grows across port-0 wins while port 1 waits
      if (!pend1) begin
        starve_cnt <= '0;
      end else if (state == IDLE) begin
        if (arb_pick)                       starve_cnt <= '0;
        else if (starve_cnt != STARVE_MAX)  starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  // RAM side: addresses/data follow the owner, valids only in their phase
  assign axi_ram.awaddr  = sel_awaddr;
  assign axi_ram.awlen   = sel_awlen;
  assign axi_ram.awvalid = in_aw && sel_awvalid;
  assign axi_ram.araddr  = sel_araddr;
  assign axi_ram.arlen   = sel_arlen;
  assign axi_ram.arvalid = in_ar && sel_arvalid;
  assign axi_ram.wdata   = sel_wdata;
  assign axi_ram.wvalid  = in_w && sel_wvalid;
  assign axi_ram.rready  = in_r && sel_rready;
  assign axi_ram.bready  = in_b && sel_bready;

  // Requester side: only the granted port ever sees a ready/valid
  assign axi_m0.awready = in_aw && !grant && axi_ram.awready;
  assign axi_m0.arready = in_ar && !grant && axi_ram.arready;
  assign axi_m0.wready  = in_w  && !grant && axi_ram.wready;
  assign axi_m0.rvalid  = in_r  && !grant && axi_ram.rvalid;
  assign axi_m0.bvalid  = in_b  && !grant && axi_ram.bvalid;
  assign axi_m0.rdata   = axi_ram.rdata;

  assign axi_m1.awready = in_aw && grant && axi_ram.awready;
  assign axi_m1.arready = in_ar && grant && axi_ram.arready;
  assign axi_m1.wready  = in_w  && grant && axi_ram.wready;
  assign axi_m1.rvalid  = in_r  && grant && axi_ram.rvalid;
  assign axi_m1.bvalid  = in_b  && grant && axi_ram.bvalid;
  assign axi_m1.rdata   = axi_ram.rdata;

endmodule

// File: tb/tb_axi_ram_arbiter.sv
// tb/tb_axi_ram_arbiter.sv - self-checking bench for axi_ram_arbiter

module tb_axi_ram_arbiter;
  localparam int LIMIT = 4;
  localparam int PH_IDLE = 0, PH_AR = 1, PH_R = 2, PH_AW = 3, PH_W = 4, PH_B = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  axi_interface m0();
  axi_interface m1();
  axi_interface ram();

  // requester stimulus
  logic [31:0] q_awaddr [2];
  logic [31:0] q_araddr [2];
  logic [31:0] q_wdata  [2];
  logic [7:0]  q_awlen  [2];
  logic [7:0]  q_arlen  [2];
  logic [1:0]  q_awvalid = 2'b00, q_arvalid = 2'b00, q_wvalid = 2'b00;
  logic [1:0]  q_rready = 2'b11, q_bready = 2'b11;

  assign m0.awaddr = q_awaddr[0];  assign m1.awaddr = q_awaddr[1];
  assign m0.awlen  = q_awlen[0];   assign m1.awlen  = q_awlen[1];
  assign m0.araddr = q_araddr[0];  assign m1.araddr = q_araddr[1];
  assign m0.arlen  = q_arlen[0];   assign m1.arlen  = q_arlen[1];
  assign m0.wdata  = q_wdata[0];   assign m1.wdata  = q_wdata[1];
  assign m0.awvalid = q_awvalid[0]; assign m1.awvalid = q_awvalid[1];
  assign m0.arvalid = q_arvalid[0]; assign m1.arvalid = q_arvalid[1];
  assign m0.wvalid  = q_wvalid[0];  assign m1.wvalid  = q_wvalid[1];
  assign m0.rready  = q_rready[0];  assign m1.rready  = q_rready[1];
  assign m0.bready  = q_bready[0];  assign m1.bready  = q_bready[1];

  // RAM responder stimulus
  logic        r_arready = 1'b0, r_awready = 1'b1, r_wready = 1'b1;
  logic        r_rvalid = 1'b0, r_bvalid = 1'b1;
  logic [31:0] r_rdata = 32'h0;
  int          cyc = 0;
  assign ram.arready = r_arready;
  assign ram.awready = r_awready;
  assign ram.wready  = r_wready;
  assign ram.rvalid  = r_rvalid;
  assign ram.bvalid  = r_bvalid;
  assign ram.rdata   = r_rdata;

  logic [1:0] o_awready, o_arready, o_wready, o_rvalid, o_bvalid;
  assign o_awready = {m1.awready, m0.awready};
  assign o_arready = {m1.arready, m0.arready};
  assign o_wready  = {m1.wready,  m0.wready};
  assign o_rvalid  = {m1.rvalid,  m0.rvalid};
  assign o_bvalid  = {m1.bvalid,  m0.bvalid};

  logic any_out;
  assign any_out = |{o_awready, o_arready, o_wready, o_rvalid, o_bvalid,
                     ram.awvalid, ram.arvalid, ram.wvalid, ram.rready, ram.bready};

  axi_ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n), .axi_m0(m0), .axi_m1(m1), .axi_ram(ram)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk_int(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic chk_str(input string nm, input string act, input string exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got \"%s\", want \"%s\"", nm, act, exp);
  endtask

  // Event log: port*10 + {1 aw accepted, 2 write done, 3 ar accepted, 4 read done}
  int evlog[$];
  function automatic string log_str();
    string s = "";
    foreach (evlog[i]) s = {s, $sformatf("%0d,", evlog[i])};
    return s;
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      r_rvalid  = (cyc % 4) != 3;
      r_arready = (cyc % 3) != 0;
      r_rdata   = 32'hD000_0000 ^ 32'(cyc);
    end
  end

  // Transaction-level reference: owner, phase and beats still owed
  int m_ph = PH_IDLE, m_own = 0, m_left = 0, m_starve = 0;
  initial begin
    bit p0, p1;
    int w;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_ph = PH_IDLE; m_own = 0; m_left = 0; m_starve = 0;
      end else begin
        p0 = q_awvalid[0] | q_arvalid[0];
        p1 = q_awvalid[1] | q_arvalid[1];
        case (m_ph)
          PH_IDLE: if (p0 || p1) begin
            w = (!p0 || (p1 && m_starve >= LIMIT)) ? 1 : 0;
            m_own = w;
            m_ph = q_awvalid[w] ? PH_AW : PH_AR;
            if (w == 1) m_starve = 0;
            else if (p1 && m_starve < LIMIT) m_starve++;
          end
          PH_AR: if (q_arvalid[m_own] && r_arready) begin
            m_left = int'(q_arlen[m_own]) + 1; m_ph = PH_R;
          end
          PH_R: if (r_rvalid && q_rready[m_own]) begin
            m_left--; if (m_left == 0) m_ph = PH_IDLE;
          end
          PH_AW: if (q_awvalid[m_own] && r_awready) begin
            m_left = int'(q_awlen[m_own]) + 1; m_ph = PH_W;
          end
          PH_W: if (q_wvalid[m_own] && r_wready) begin
            m_left--; if (m_left == 0) m_ph = PH_B;
          end
          PH_B: if (r_bvalid && q_bready[m_own]) m_ph = PH_IDLE;
          default: m_ph = PH_IDLE;
        endcase
        if (!p1) m_starve = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the reference
  bit cmp_on = 1'b1;
  bit watch_m1 = 1'b0;
  bit m1_seen = 1'b0;
  logic [1:0] e_awr, e_arr, e_wr, e_rv, e_bv;
  logic [4:0] e_ram;
  logic [190:0] exp_v, act_v;
  initial begin
    bit own;
    forever begin
      @(negedge clk);
      if (watch_m1 && (o_awready[1] | o_arready[1] | o_wready[1] | o_rvalid[1] | o_bvalid[1]))
        m1_seen = 1'b1;
      if (cmp_on) begin
        for (int p = 0; p < 2; p++) begin
          own = reset_n && (m_own == p);
          e_awr[p] = own && m_ph == PH_AW && r_awready;
          e_arr[p] = own && m_ph == PH_AR && r_arready;
          e_wr[p]  = own && m_ph == PH_W  && r_wready;
          e_rv[p]  = own && m_ph == PH_R  && r_rvalid;
          e_bv[p]  = own && m_ph == PH_B  && r_bvalid;
        end
        e_ram = reset_n ? {m_ph == PH_AW && q_awvalid[m_own], m_ph == PH_AR && q_arvalid[m_own],
                           m_ph == PH_W && q_wvalid[m_own], m_ph == PH_R && q_rready[m_own],
                           m_ph == PH_B && q_bready[m_own]} : 5'b0;
        exp_v = {e_awr, e_arr, e_wr, e_rv, e_bv, e_ram,
                 e_rv[0] ? r_rdata : 32'h0, e_rv[1] ? r_rdata : 32'h0,
                 e_ram[3] ? {q_araddr[m_own], q_arlen[m_own]} : 40'h0,
                 e_ram[4] ? {q_awaddr[m_own], q_awlen[m_own]} : 40'h0,
                 e_ram[2] ? q_wdata[m_own] : 32'h0};
        act_v = {o_awready, o_arready, o_wready, o_rvalid, o_bvalid,
                 ram.awvalid, ram.arvalid, ram.wvalid, ram.rready, ram.bready,
                 e_rv[0] ? m0.rdata : 32'h0, e_rv[1] ? m1.rdata : 32'h0,
                 e_ram[3] ? {ram.araddr, ram.arlen} : 40'h0,
                 e_ram[4] ? {ram.awaddr, ram.awlen} : 40'h0,
                 e_ram[2] ? ram.wdata : 32'h0};
        n_checks++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL cycle_outputs @%0t: got %h want %h", $time, act_v, exp_v);
      end
    end
  end

  task automatic do_read(input int p, input logic [31:0] a, input logic [7:0] len,
                         output int beats, output logic [31:0] ram_addr);
    int n = 0;
    bit hs = 0;
    ram_addr = 32'h0;
    q_araddr[p] = a; q_arlen[p] = len; q_arvalid[p] = 1'b1;
    while (!hs && n < 400) begin
      @(negedge clk); n++;
      if (o_arready[p]) begin hs = 1; ram_addr = ram.araddr; evlog.push_back(p*10 + 3); end
      @(posedge clk); #1;
    end
    q_arvalid[p] = 1'b0;
    chk_int("ar_handshake", hs, 1);
    beats = 0; n = 0;
    while (beats < int'(len) + 1 && n < 2000) begin
      @(negedge clk); n++;
      if (o_rvalid[p]) begin
        beats++;
        if (beats == int'(len) + 1) evlog.push_back(p*10 + 4);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_write(input int p, input logic [31:0] a, input logic [7:0] len,
                          input int dly, output int beats, output int cycles);
    int n = 0;
    bit hs = 0;
    time t0;
    q_awaddr[p] = a; q_awlen[p] = len; q_awvalid[p] = 1'b1; q_wvalid[p] = 1'b0;
    while (!hs && n < 400) begin
      @(negedge clk); n++;
      if (o_awready[p]) begin hs = 1; evlog.push_back(p*10 + 1); end
      @(posedge clk); #1;
    end
    q_awvalid[p] = 1'b0;
    chk_int("aw_handshake", hs, 1);
    t0 = $time;
    repeat (dly) begin @(posedge clk); #1; end
    beats = 0; n = 0; q_wvalid[p] = 1'b1;
    while (beats < int'(len) + 1 && n < 2000) begin
      q_wdata[p] = a ^ 32'(beats);
      @(negedge clk); n++;
      if (o_wready[p]) beats++;
      @(posedge clk); #1;
    end
    q_wvalid[p] = 1'b0;
    hs = 0; n = 0;
    while (!hs && n < 400) begin
      @(negedge clk); n++;
      if (o_bvalid[p]) begin hs = 1; evlog.push_back(p*10 + 2); end
      @(posedge clk); #1;
    end
    chk_int("b_handshake", hs, 1);
    cycles = int'(($time - t0) / 10);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int b0, b1, wb0, wb1, cy0, cy1, n;
    logic [31:0] ra0, ra1;
    bit hs;
    for (int i = 0; i < 2; i++) begin
      q_awaddr[i] = 0; q_araddr[i] = 0; q_wdata[i] = 0; q_awlen[i] = 0; q_arlen[i] = 0;
    end

    // Requests present during reset must not leak through
    q_arvalid[0] = 1'b1; q_awvalid[1] = 1'b1;
    @(negedge clk);
    chk_int("reset_quiet", any_out, 0);
    @(posedge clk); #1;
    q_arvalid = 2'b00; q_awvalid = 2'b00;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // m0 4-beat read, m1 untouched
    watch_m1 = 1'b1;
    do_read(0, 32'h100, 8'd3, b0, ra0);
    watch_m1 = 1'b0;
    chk_int("m0_read_beats", b0, 4);
    chk_int("m0_read_ram_addr", ra0, 32'h100);
    chk_int("m1_no_valid", m1_seen, 0);

    // m0 write and read together: write first
    evlog.delete();
    fork
      do_write(0, 32'h140, 8'd0, 0, wb0, cy0);
      do_read(0, 32'h180, 8'd1, b0, ra0);
    join
    chk_str("m0_write_before_read", log_str(), "1,2,3,4,");
    chk_int("m0_wr_then_rd_beats", b0, 2);

    // both write: m0 first, m1 only after m0 response
    evlog.delete();
    fork
      do_write(0, 32'h200, 8'd1, 0, wb0, cy0);
      do_write(1, 32'h240, 8'd2, 0, wb1, cy1);
    join
    chk_str("both_write_order", log_str(), "1,2,11,12,");
    chk_int("m0_write_beats", wb0, 2);
    chk_int("m1_write_beats", wb1, 3);

    // m1 single-beat write with data delayed 5 cycles
    do_write(1, 32'h600, 8'd0, 5, wb1, cy1);
    chk_int("delayed_write_beats", wb1, 1);
    chk_int("delayed_write_aw_to_b_cycles", cy1, 7);

    // starvation: m1 wins after exactly 4 m0 reads
    evlog.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) do_read(0, 32'h300 + 32'(i*4), 8'd0, b0, ra0);
      end
      do_read(1, 32'h380, 8'd0, b1, ra1);
    join
    chk_str("starvation_order", log_str(), "3,4,3,4,3,4,3,4,13,14,3,4,3,4,");
    chk_int("starved_read_addr", ra1, 32'h380);

    // maximum bursts
    do_read(1, 32'h800, 8'd255, b1, ra1);
    chk_int("read_256_beats", b1, 256);
    do_write(0, 32'h900, 8'd255, 0, wb0, cy0);
    chk_int("write_256_beats", wb0, 256);

    // reset in the middle of an 8-beat read
    q_araddr[0] = 32'h400; q_arlen[0] = 8'd7; q_arvalid[0] = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 100) begin
      @(negedge clk); n++;
      if (o_arready[0]) hs = 1;
      @(posedge clk); #1;
    end
    q_arvalid[0] = 1'b0;
    chk_int("reset_test_ar", hs, 1);
    b0 = 0; n = 0;
    while (b0 < 2 && n < 100) begin
      @(negedge clk); n++;
      if (o_rvalid[0]) b0++;
      @(posedge clk); #1;
    end
    chk_int("reset_test_pre_beats", b0, 2);
    reset_n = 1'b0;
    @(negedge clk);
    chk_int("quiet_in_reset", any_out, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk_int("quiet_after_reset", any_out, 0);
    @(posedge clk); #1;
    do_read(0, 32'h500, 8'd1, b0, ra0);
    chk_int("post_reset_read_beats", b0, 2);
    chk_int("post_reset_read_addr", ra0, 32'h500);

    repeat (3) @(posedge clk);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_ram_arbiter.md
AXI_RAM_ARBITER -- requirements
Module: axi_ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive port-0 grants while port 1 is waiting.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port axi_m0, axi_interface.slave: requester 0 (high priority, L2 cache).
REQ-005 SHALL have port axi_m1, axi_interface.slave: requester 1 (low priority, loader/DMA).
REQ-006 SHALL have port axi_ram, axi_interface.master: the single shared path to the internal RAM.
REQ-007 SHALL use the following channel fields: awaddr/araddr 32, awlen/arlen 8, awvalid/awready, arvalid/arready, wdata 32, wvalid/wready, rdata 32, rvalid/rready, bvalid/bready.

Function
REQ-008 SHALL implement states IDLE, READ_ADDR, READ_DATA, WRITE_ADDR, WRITE_DATA and WRITE_RESP, plus a 1-bit grant register and an 8-bit beat counter.
REQ-009 SHALL arbitrate only in IDLE; a requester is pending when its awvalid or arvalid is asserted.
REQ-010 SHALL normally grant port 0 when both ports are pending.
REQ-011 SHALL grant port 1 instead when the starvation counter equals STARVE_LIMIT.
REQ-012 SHALL increment the starvation counter on each port-0 grant made while port 1 is pending, saturating at STARVE_LIMIT.
REQ-013 SHALL clear the starvation counter on any port-1 grant or whenever port 1 is not pending.
REQ-014 SHALL, on a grant with awvalid set, go to WRITE_ADDR; otherwise go to READ_ADDR. Write wins over read within one port.
REQ-015 SHALL hold all requester ready/valid outputs at 0 while in IDLE; arbitration consumes one cycle.
REQ-016 SHALL, in READ_ADDR, forward the granted araddr/arlen/arvalid to axi_ram and return axi_ram.arready to the granted port only.
REQ-017 SHALL, on the ar handshake in READ_ADDR, load the beat counter with arlen and go to READ_DATA.
REQ-018 SHALL, in READ_DATA, pass rdata/rvalid to the granted port and its rready back to axi_ram.
REQ-019 SHALL, in READ_DATA, decrement the counter on each rvalid&&rready beat, and go to IDLE on the beat where the counter is 0 (arlen+1 beats total).
REQ-020 SHALL, in WRITE_ADDR, forward awaddr/awlen/awvalid and awready analogously, load the counter with awlen, and go to WRITE_DATA.
REQ-021 SHALL, in WRITE_DATA, forward wdata/wvalid and wready, decrement the counter per wvalid&&wready beat, and go to WRITE_RESP on the last beat.
REQ-022 SHALL, in WRITE_RESP, forward bvalid and bready, and go to IDLE on bvalid&&bready.
REQ-023 SHALL drive all non-granted port outputs (arready, awready, wready, rvalid, bvalid) to 0 at all times.
REQ-024 SHALL drive all axi_ram request valids to 0 outside their forwarding state.
REQ-025 SHALL treat the grant as fixed from leaving IDLE until returning to IDLE; requester valid changes SHALL NOT alter the grant mid-transaction.
REQ-026 SHALL handle an arlen/awlen of 0 as a single beat, and 255 as 256 beats with no counter wrap.
REQ-027 SHALL require no added latency on data beats: forwarding is combinational, with only the state and counter registered.

Reset
REQ-028 SHALL, while reset_n is 0 at a clk edge, set state to IDLE, grant to 0, beat counter to 0 and starvation counter to 0.
REQ-029 SHALL hold all outputs to requesters and axi_ram at 0 (valids/readies) during reset.
REQ-030 SHALL abandon any in-flight transaction on reset; after reset_n rises, the first action SHALL be arbitration in IDLE.

Verification
REQ-031 SHALL cover: m0 read araddr=0x100, arlen=3 -> axi_ram sees araddr 0x100 and m0 receives exactly 4 rvalid beats; m1 sees no valid.
REQ-032 SHALL cover: m0 and m1 both awvalid in IDLE -> m0 granted first; m1's write starts only after m0's bvalid&&bready.
REQ-033 SHALL cover: m0 continuously requesting single-beat reads while m1 waits, STARVE_LIMIT=4 -> m1 granted after exactly 4 m0 transactions.
REQ-034 SHALL cover: m1 write awlen=0, wvalid delayed 5 cycles -> WRITE_DATA holds, one write beat, then WRITE_RESP, then IDLE.
REQ-035 SHALL cover: reset_n=0 asserted mid-READ_DATA (beat 2 of 8) -> next cycle state is IDLE, all readies/valids are 0, and a new read completes normally.
REQ-036 SHALL cover: m0 awvalid and arvalid together -> write serviced first, then the read at the next arbitration.
